// File: rtl/posit_mac_sched_if.sv
// posit_mac_sched_if: groups the two streaming sides of the posit MAC scheduler.
// The MAC side carries win_o/din_o/vld_mac_o out and acc_i/vld_acc_i back.
// The result side carries res_o/res_idx_o/res_vld_o out and res_rdy_i back.
// The master modport is the scheduler. The slave modport is the MAC plus the result consumer.
interface posit_mac_sched_if #(
    parameter int WIDTH = 8,
    parameter int NOUT  = 4
);
    localparam int IW = (NOUT > 1) ? $clog2(NOUT) : 1;

    // MAC input burst
    logic [WIDTH-1:0] win_o;
    logic [WIDTH-1:0] din_o;
    logic             vld_mac_o;
    // MAC result pulse
    logic [WIDTH-1:0] acc_i;
    logic             vld_acc_i;
    // Result valid/ready port
    logic [WIDTH-1:0] res_o;
    logic [IW-1:0]    res_idx_o;
    logic             res_vld_o;
    logic             res_rdy_i;

    modport master (
        output win_o, din_o, vld_mac_o,
        input  acc_i, vld_acc_i,
        output res_o, res_idx_o, res_vld_o,
        input  res_rdy_i
    );

    modport slave (
        input  win_o, din_o, vld_mac_o,
        output acc_i, vld_acc_i,
        input  res_o, res_idx_o, res_vld_o,
        output res_rdy_i
    );
endinterface

// File: rtl/posit_mac_sched.sv
// posit_mac_sched: upstream sequencer for the posit MAC stage.
// The block holds one activation vector of K posits and NOUT weight rows of K posits each.
// Each row is streamed as one contiguous K-beat burst. The block then waits for the MAC
// result pulse and hands the result out on a valid/ready port, tagged with its row index.
// A result held in HOLD keeps the MAC idle for at least one cycle before the next burst.
// Optional feature: defining POSIT_SCHED_RELU_EN clamps negative (non-NaR) results to 0 at capture.
module posit_mac_sched #(
    parameter int WIDTH = 8,
    parameter int K     = 4,
    parameter int NOUT  = 4,
    parameter int TMO   = 32
) (
    input  logic                      clk_i,
    input  logic                      rstn,
    input  logic                      wr_en_i,
    input  logic                      wr_sel_i,
    input  logic [$clog2(NOUT*K)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]          wr_data_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    posit_mac_sched_if.master         bus
);
    localparam int AW = $clog2(NOUT*K);
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int RW = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(NOUT - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    // Operand buffers
    logic [WIDTH-1:0] r_wbuf [NOUT*K];
    logic [WIDTH-1:0] r_dbuf [K];

    // Control state
    state_t        r_state;
    logic [KW-1:0] r_k;
    logic [RW-1:0] r_row;
    logic [AW-1:0] r_base;   // r_row * K, tracked incrementally
    logic [TW-1:0] r_tmo;

    // Registered outputs
    logic [WIDTH-1:0] r_win;
    logic [WIDTH-1:0] r_din;
    logic             r_vld_mac;
    logic [WIDTH-1:0] r_res;
    logic [RW-1:0]    r_res_idx;
    logic             r_res_vld;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    // Address helpers
    logic [AW-1:0]    w_next_row_base;
    logic [AW-1:0]    w_next_beat_addr;
    logic [KW-1:0]    w_next_k;
    logic             w_waddr_ok;
    logic             w_daddr_ok;
    logic [WIDTH-1:0] w_res_cap;

    assign w_next_row_base  = r_base + AW'(K);
    assign w_next_beat_addr = r_base + AW'(r_k) + AW'(1);
    assign w_next_k         = r_k + KW'(1);
    assign w_waddr_ok       = (int'(wr_addr_i) < NOUT * K);
    assign w_daddr_ok       = (int'(wr_addr_i[KW-1:0]) < K);

    // Pick the value latched into res_o when the MAC result arrives.
    always_comb begin
        // NOTE: a default assignment comes first so that no path leaves w_res_cap unassigned; an unassigned path would infer a latch.
        w_res_cap = bus.acc_i;
`ifdef POSIT_SCHED_RELU_EN
        if (bus.acc_i[WIDTH-1] && (bus.acc_i != {1'b1, {(WIDTH-1){1'b0}}})) begin
            w_res_cap = '0;
        end
`endif
    end

    // Buffer writes; both buffers are frozen while a job is running.
    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            // NOTE: the buffers are reset on purpose, because a reset must leave every entry reading back as 0. Plain storage arrays normally get no reset.
            for (int i = 0; i < NOUT * K; i++) begin
                r_wbuf[i] <= '0;
            end
            for (int i = 0; i < K; i++) begin
                r_dbuf[i] <= '0;
            end
        end else if (wr_en_i && !r_busy) begin
            // NOTE: sequential state always uses <=, so every register samples values from before the edge.
            if (wr_sel_i) begin
                if (w_waddr_ok) begin
                    r_wbuf[wr_addr_i] <= wr_data_i;
                end
            end else if (w_daddr_ok) begin
                r_dbuf[wr_addr_i[KW-1:0]] <= wr_data_i;
            end
        end
    end

    // Job FSM: issue bursts, wait for the MAC result, hold it for the consumer, frame the job.
    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_row     <= '0;
            r_base    <= '0;
            r_tmo     <= '0;
            r_win     <= '0;
            r_din     <= '0;
            r_vld_mac <= 1'b0;
            r_res     <= '0;
            r_res_idx <= '0;
            r_res_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_err     <= 1'b0;
                        r_row     <= '0;
                        r_base    <= '0;
                        r_k       <= '0;
                        r_busy    <= 1'b1;
                        r_win     <= r_wbuf[AW'(0)];
                        r_din     <= r_dbuf[KW'(0)];
                        r_vld_mac <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_k == K_LAST) begin
                        r_vld_mac <= 1'b0;
                        r_win     <= '0;
                        r_din     <= '0;
                        r_tmo     <= '0;
                        r_state   <= S_WAIT;
                    end else begin
                        r_k   <= w_next_k;
                        r_win <= r_wbuf[w_next_beat_addr];
                        r_din <= r_dbuf[w_next_k];
                    end
                end
                S_WAIT: begin
                    if (bus.vld_acc_i) begin
                        r_res     <= w_res_cap;
                        r_res_idx <= r_row;
                        r_res_vld <= 1'b1;
                        r_state   <= S_HOLD;
                    end else if (r_tmo == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_HOLD: begin
                    // The earliest exit is one cycle after capture, which gives the MAC its idle cycle.
                    if (r_res_vld && bus.res_rdy_i) begin
                        r_res_vld <= 1'b0;
                        if (r_row == ROW_LAST) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row     <= r_row + RW'(1);
                            r_base    <= w_next_row_base;
                            r_k       <= '0;
                            r_win     <= r_wbuf[w_next_row_base];
                            r_din     <= r_dbuf[KW'(0)];
                            r_vld_mac <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign bus.win_o     = r_win;
    assign bus.din_o     = r_din;
    assign bus.vld_mac_o = r_vld_mac;
    assign bus.res_o     = r_res;
    assign bus.res_idx_o = r_res_idx;
    assign bus.res_vld_o = r_res_vld;
endmodule

// File: tb/tb_posit_mac_sched.sv
// tb_posit_mac_sched: scoreboard bench for posit_mac_sched.
// A behavioural MAC answers bursts made of posit8 (es=2) operands 0x40 (+1), 0xC0 (-1) and 0x00.
// The MAC returns the dot product three cycles after the last beat.
module tb_posit_mac_sched;
    localparam int WIDTH = 8;
    localparam int K     = 4;
    localparam int NOUT  = 4;
    localparam int TMO   = 32;
    localparam int LAT   = 3;

    logic       clk_i = 1'b0;
    logic       rstn;
    logic       wr_en_i;
    logic       wr_sel_i;
    logic [3:0] wr_addr_i;
    logic [7:0] wr_data_i;
    logic       start_i;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    posit_mac_sched_if #(.WIDTH(WIDTH), .NOUT(NOUT)) bus ();

    posit_mac_sched #(.WIDTH(WIDTH), .K(K), .NOUT(NOUT), .TMO(TMO)) dut (
        .clk_i     (clk_i),
        .rstn      (rstn),
        .wr_en_i   (wr_en_i),
        .wr_sel_i  (wr_sel_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .bus       (bus)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] res;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_w [NOUT*K];
    logic [7:0] exp_d [K];
    int         n_chk = 0;
    int         n_pass = 0;

    // MAC model state
    bit mac_en = 1'b1;
    int beat = 0, sum = 0, sum_done = 0, cd = 0, burst_no = 0, n_vld = 0;
    int t_acc = -100, t_accept = -100, t_last = -100;
    int stall_left = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic int val(input logic [7:0] p);
        if (p == 8'h40) return 1;
        if (p == 8'hC0) return -1;
        return 0;
    endfunction

    // posit8 es=2 encodings for small integers
    function automatic logic [7:0] enc(input int s);
        int         a;
        logic [7:0] m;
        a = (s < 0) ? -s : s;
        case (a)
            0: m = 8'h00;
            1: m = 8'h40;
            2: m = 8'h48;
            3: m = 8'h4C;
            4: m = 8'h50;
            default: m = 8'h7F;
        endcase
        return (s < 0) ? 8'(8'h00 - m) : m;
    endfunction

    function automatic logic [7:0] exp_res(input int r);
        int         s;
        logic [7:0] v;
        s = 0;
        for (int k = 0; k < K; k++) s += val(exp_w[r*K+k]) * val(exp_d[k]);
        v = enc(s);
`ifdef POSIT_SCHED_RELU_EN
        if (v[7] && v != 8'h80) v = 8'h00;
`endif
        return v;
    endfunction

    // Behavioural MAC: checks operands and framing, returns result LAT cycles after the last beat.
    initial begin
        bus.vld_acc_i = 1'b0;
        bus.acc_i     = '0;
        forever begin
            @(negedge clk_i);
            bus.vld_acc_i = 1'b0;
            if (!rstn) begin
                beat = 0;
                sum  = 0;
                cd   = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0 && mac_en) begin
                        bus.vld_acc_i = 1'b1;
                        bus.acc_i     = enc(sum_done);
                        t_acc         = cyc;
                    end
                end
                if (beat != 0) check("burst_contiguous", 32'(bus.vld_mac_o), 1);
                if (bus.vld_mac_o) begin
                    if (beat == 0) begin
                        check("idle_after_acc", 32'(cyc >= t_acc + 2), 1);
                        check("burst_after_accept", 32'(cyc > t_accept), 1);
                    end
                    check("win", 32'(bus.win_o), 32'(exp_w[(burst_no % NOUT)*K + beat]));
                    check("din", 32'(bus.din_o), 32'(exp_d[beat]));
                    sum += val(bus.win_o) * val(bus.din_o);
                    beat++;
                    n_vld++;
                    if (beat == K) begin
                        sum_done = sum;
                        sum      = 0;
                        beat     = 0;
                        burst_no++;
                        cd       = LAT;
                        t_last   = cyc;
                    end
                end
            end
        end
    end

    // Result monitor: compares presented results with the scoreboard head, pops on transfer.
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (rstn && bus.res_vld_o) begin
                check("no_issue_in_hold", 32'(bus.vld_mac_o), 0);
                check("result_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    check("res_o", 32'(bus.res_o), 32'(sb[0].res));
                    check("res_idx_o", 32'(bus.res_idx_o), 32'(sb[0].idx));
                    if (bus.res_rdy_i) begin
                        void'(sb.pop_front());
                        t_accept = cyc;
                    end
                end
            end
        end
    end

    task automatic wr(input bit sel, input int addr, input logic [7:0] d);
        @(negedge clk_i);
        wr_en_i   = 1'b1;
        wr_sel_i  = sel;
        wr_addr_i = 4'(addr);
        wr_data_i = d;
        if (sel) exp_w[addr] = d;
        else     exp_d[addr] = d;
        @(negedge clk_i);
        wr_en_i = 1'b0;
    endtask

    task automatic run_job(input bit mac_on, input int stall, input bit poke, input bit exp_err);
        int n_done;
        int done_cyc;
        mac_en     = mac_on;
        n_vld      = 0;
        burst_no   = 0;
        stall_left = stall;
        if (!exp_err) begin
            for (int r = 0; r < NOUT; r++) sb.push_back('{idx: 2'(r), res: exp_res(r)});
        end
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("busy_rise", 32'(busy_o), 1);
        check("err_cleared_on_start", 32'(err_o), 0);
        check("first_beat", 32'(bus.vld_mac_o), 1);
        n_done   = 0;
        done_cyc = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            if (stall_left > 0 && bus.res_vld_o) begin
                bus.res_rdy_i = 1'b0;
                stall_left--;
            end else begin
                bus.res_rdy_i = 1'b1;
            end
            if (poke) begin
                if (i == 5) begin
                    check("busy_during_poke", 32'(busy_o), 1);
                    wr_en_i = 1'b1; wr_sel_i = 1'b1; wr_addr_i = 4'd0; wr_data_i = 8'h7F;
                    start_i = 1'b1;
                end else if (i == 6) begin
                    wr_sel_i = 1'b0; wr_addr_i = 4'd1; wr_data_i = 8'h7F;
                    start_i  = 1'b0;
                end else if (i == 7) begin
                    wr_en_i = 1'b0;
                end
            end
            if (done_o) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check("err_at_done", 32'(err_o), 32'(exp_err));
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) check("busy_fall", 32'(busy_o), 0);
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        check("done_pulses", 32'(n_done), 1);
        check("vld_mac_cycles", 32'(n_vld), exp_err ? 32'(K) : 32'(NOUT*K));
        check("err_sticky", 32'(err_o), 32'(exp_err));
        check("sb_drained", 32'(sb.size()), 0);
        if (exp_err) check("timeout_latency", 32'(done_cyc - t_last), 32'(TMO + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start_i = 1'b0; wr_en_i = 1'b0; wr_sel_i = 1'b0;
        wr_addr_i = '0; wr_data_i = '0; bus.res_rdy_i = 1'b1;
        for (int i = 0; i < NOUT*K; i++) exp_w[i] = 8'h00;
        for (int i = 0; i < K; i++) exp_d[i] = 8'h00;
        repeat (3) @(negedge clk_i);
        rstn = 1'b1;
        @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_vld_mac", 32'(bus.vld_mac_o), 0);
        check("rst_win", 32'(bus.win_o), 0);
        check("rst_din", 32'(bus.din_o), 0);
        check("rst_res_vld", 32'(bus.res_vld_o), 0);
        check("rst_res", 32'(bus.res_o), 0);
        check("rst_res_idx", 32'(bus.res_idx_o), 0);

        // All ones: every row yields 4.0
        for (int k = 0; k < K; k++) wr(1'b0, k, 8'h40);
        for (int a = 0; a < NOUT*K; a++) wr(1'b1, a, 8'h40);
        run_job(1'b1, 0, 1'b0, 1'b0);

        // Row 2 negated: -4.0 (or 0 with ReLU)
        for (int k = 0; k < K; k++) wr(1'b1, 2*K + k, 8'hC0);
        run_job(1'b1, 0, 1'b0, 1'b0);

        // Consumer stall after the first result
        run_job(1'b1, 10, 1'b0, 1'b0);

        // MAC that never answers: timeout
        run_job(1'b0, 0, 1'b0, 1'b1);

        // Writes and start while busy are ignored; the following job sees unchanged buffers
        run_job(1'b1, 0, 1'b1, 1'b0);
        run_job(1'b1, 0, 1'b0, 1'b0);

        // Reset during beat 2 of the first burst
        mac_en = 1'b1; burst_no = 0; n_vld = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("beat2_active", 32'(bus.vld_mac_o), 1);
        rstn = 1'b0;
        @(negedge clk_i);
        check("mid_rst_vld_mac", 32'(bus.vld_mac_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_res_vld", 32'(bus.res_vld_o), 0);
        check("mid_rst_done", 32'(done_o), 0);
        @(negedge clk_i);
        rstn = 1'b1;
        sb.delete();
        @(negedge clk_i);
        check("post_rst_done", 32'(done_o), 0);

        // Buffers read back as zero after reset
        for (int i = 0; i < NOUT*K; i++) exp_w[i] = 8'h00;
        for (int i = 0; i < K; i++) exp_d[i] = 8'h00;
        run_job(1'b1, 0, 1'b0, 1'b0);

        repeat (3) @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
